// File: rtl/sar_pkg.sv
// Shared types and limits for the SAR CDAC/comparator responder.
// State encodings, switch count and parameter ranges.
package sar_pkg;

  localparam int NSW      = 7;
  localparam int N_MIN    = 1;
  localparam int N_MAX    = 7;
  localparam int FRAC_MIN = 0;
  localparam int FRAC_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_rise_det.sv
// Registered rising-edge detector, async active-low reset.
// rise is combinational from sig and the previous-cycle register.
module sar_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/sar_cdac_comp_model.sv
// Digital CDAC + comparator responder for the SAR FSM interface.
// Samples vin_code, answers comparator strobes, flags protocol misuse.
module sar_cdac_comp_model
  import sar_pkg::*;
#(
  parameter int N    = 4,
  parameter int FRAC = 2
) (
  input  logic              clk_1Mhz,
  input  logic              reset,
  input  logic              S2b,
  input  logic              comp_clk,
  input  logic [NSW:1]      S,
  input  logic [N+FRAC-1:0] vin_code,
  output logic              decision,
  output logic [N+FRAC-1:0] held_code,
  output logic [2:0]        cmp_count,
  output logic              conv_done,
  output logic              protocol_err,
  input  logic              err_clr
);

  localparam int         W    = N + FRAC;
  localparam logic [2:0] NCNT = 3'(N);

  sar_state_t     state, state_n;
  logic [W-1:0]   held_n;
  logic           dec_n;
  logic [2:0]     cnt_n;
  logic [2:0]     cnt_inc;
  logic           done_n;
  logic           err_n;
  logic           err_det;
  logic           rise;
  logic [NSW-1:0] sw;
  logic [W-1:0]   dac;
  logic           cmp;
  logic           hi_sw;

  sar_rise_det u_rise (
    .clk   (clk_1Mhz),
    .rst_n (reset),
    .sig   (comp_clk),
    .rise  (rise)
  );

  // Only S[N:1] feed the DAC; anything above is a misuse flag.
  assign sw      = S;
  assign dac     = W'(sw[N-1:0]) << FRAC;
  assign cmp     = (held_code >= dac);
  assign hi_sw   = |(sw >> N);
  assign cnt_inc = cmp_count + 3'd1;

  always_comb begin
    state_n = state;
    held_n  = held_code;
    dec_n   = decision;
    cnt_n   = cmp_count;
    done_n  = 1'b0;
    err_det = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) err_det = 1'b1;
        if (S2b)  state_n = SAMPLE;
      end
      SAMPLE: begin
        if (rise) err_det = 1'b1;
        if (S2b) begin
          held_n = vin_code;
        end else begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (hi_sw) err_det = 1'b1;
        if (S2b) begin
          // Early return to track aborts the conversion.
          if (cmp_count < NCNT) err_det = 1'b1;
          state_n = SAMPLE;
          cnt_n   = '0;
        end else if (rise && cmp_count < NCNT) begin
          dec_n = cmp;
          cnt_n = cnt_inc;
          if (cnt_inc == NCNT) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        if (rise) err_det = 1'b1;
        if (S2b)  state_n = SAMPLE;
      end
      default: state_n = IDLE;
    endcase
    err_n = err_det | (protocol_err & ~err_clr);
  end

  always_ff @(posedge clk_1Mhz or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      held_code    <= '0;
      decision     <= 1'b0;
      cmp_count    <= '0;
      conv_done    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_n;
      held_code    <= held_n;
      decision     <= dec_n;
      cmp_count    <= cnt_n;
      conv_done    <= done_n;
      protocol_err <= err_n;
    end
  end

endmodule

// File: tb/tb_sar_cdac_comp_model.sv
// Self-checking bench for sar_cdac_comp_model (N=4, FRAC=2).
// Acts as the SAR FSM; expectations come from plain arithmetic.
module tb_sar_cdac_comp_model;

  localparam int N    = 4;
  localparam int FRAC = 2;
  localparam int W    = N + FRAC;

  logic         clk_1Mhz = 1'b0;
  logic         reset    = 1'b0;
  logic         S2b      = 1'b0;
  logic         comp_clk = 1'b0;
  logic         err_clr  = 1'b0;
  logic [7:1]   S        = '0;
  logic [W-1:0] vin_code = '0;
  logic         decision;
  logic [W-1:0] held_code;
  logic [2:0]   cmp_count;
  logic         conv_done;
  logic         protocol_err;

  int errors = 0;
  int checks = 0;

  sar_cdac_comp_model #(.N(N), .FRAC(FRAC)) dut (
    .clk_1Mhz     (clk_1Mhz),
    .reset        (reset),
    .S2b          (S2b),
    .comp_clk     (comp_clk),
    .S            (S),
    .vin_code     (vin_code),
    .decision     (decision),
    .held_code    (held_code),
    .cmp_count    (cmp_count),
    .conv_done    (conv_done),
    .protocol_err (protocol_err),
    .err_clr      (err_clr)
  );

  always #5 clk_1Mhz = ~clk_1Mhz;

  task automatic step();
    @(posedge clk_1Mhz);
    #1;
  endtask

  function automatic logic ref_dec(input int v, input int trial);
    return (v >= (trial << FRAC)) ? 1'b1 : 1'b0;
  endfunction

  task automatic sample(input int v);
    S2b      = 1'b1;
    vin_code = W'(v);
    step();
    step();
    step();
    S2b = 1'b0;
    step();
  endtask

  task automatic strobe(input int sw, output logic d,
                        output logic [2:0] c, output logic dn,
                        output logic er, output logic dn2);
    S        = 7'(sw);
    comp_clk = 1'b1;
    step();
    d  = decision;
    c  = cmp_count;
    dn = conv_done;
    er = protocol_err;
    comp_clk = 1'b0;
    step();
    dn2 = conv_done;
  endtask

  task automatic run_conv(input int v, input int chg, input string tag);
    int res;
    int trial;
    logic d, dn, er, dn2;
    logic [2:0] c;
    res = 0;
    sample(v);
    if (chg >= 0) vin_code = W'(chg);
    checks++;
    if (held_code !== W'(v)) begin
      errors++;
      $display("FAIL %s held: got %0d expected %0d", tag, held_code, v);
    end
    for (int i = N - 1; i >= 0; i--) begin
      trial = res | (1 << i);
      strobe(trial, d, c, dn, er, dn2);
      checks++;
      if (d !== ref_dec(v, trial)) begin
        errors++;
        $display("FAIL %s dec trial=%0d: got %b expected %b",
                 tag, trial, d, ref_dec(v, trial));
      end
      checks++;
      if (c !== 3'(N - i)) begin
        errors++;
        $display("FAIL %s count: got %0d expected %0d", tag, c, N - i);
      end
      checks++;
      if (dn !== (i == 0)) begin
        errors++;
        $display("FAIL %s conv_done step %0d: got %b expected %b",
                 tag, N - i, dn, (i == 0));
      end
      if (i == 0) begin
        checks++;
        if (dn2 !== 1'b0) begin
          errors++;
          $display("FAIL %s conv_done width: got %b expected 0", tag, dn2);
        end
      end
      if (d) res = trial;
    end
    checks++;
    if (res != (v >> FRAC)) begin
      errors++;
      $display("FAIL %s result: got %0d expected %0d", tag, res, v >> FRAC);
    end
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL %s protocol_err: got %b expected 0", tag, protocol_err);
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({decision, held_code, cmp_count, conv_done, protocol_err} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b expected 0",
               {decision, held_code, cmp_count, conv_done, protocol_err});
    end
    #2 reset = 1'b1;
    step();
    checks++;
    if (protocol_err !== 1'b0 || cmp_count !== 3'd0) begin
      errors++;
      $display("FAIL reset release: got err=%b cnt=%0d expected 0 0",
               protocol_err, cmp_count);
    end
  endtask

  task automatic test_conv_45();
    run_conv(45, -1, "conv45");
  endtask

  task automatic test_extremes();
    run_conv(0, -1, "conv0");
    run_conv(63, -1, "conv63");
  endtask

  task automatic test_hold_change();
    run_conv(20, 50, "hold20");
    checks++;
    if (held_code !== W'(20)) begin
      errors++;
      $display("FAIL hold_frozen: got %0d expected 20", held_code);
    end
  endtask

  task automatic test_err_sample();
    logic d0;
    S2b = 1'b1;
    step();
    step();
    d0 = decision;
    comp_clk = 1'b1;
    step();
    checks++;
    if (protocol_err !== 1'b1 || decision !== d0) begin
      errors++;
      $display("FAIL sample_strobe: got err=%b dec=%b expected 1 %b",
               protocol_err, decision, d0);
    end
    comp_clk = 1'b0;
    step();
    clear_err();
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got %b expected 0", protocol_err);
    end
    err_clr  = 1'b1;
    comp_clk = 1'b1;
    step();
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL err_wins: got %b expected 1", protocol_err);
    end
    comp_clk = 1'b0;
    step();
    err_clr = 1'b0;
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr2: got %b expected 0", protocol_err);
    end
  endtask

  task automatic test_abort();
    logic d, dn, er, dn2, d0;
    logic [2:0] c;
    sample(45);
    strobe(8, d, c, dn, er, dn2);
    strobe(8, d, c, dn, er, dn2);
    checks++;
    if (c !== 3'd2) begin
      errors++;
      $display("FAIL abort_pre: got %0d expected 2", c);
    end
    S2b = 1'b1;
    step();
    checks++;
    if (protocol_err !== 1'b1 || cmp_count !== 3'd0) begin
      errors++;
      $display("FAIL abort: got err=%b cnt=%0d expected 1 0",
               protocol_err, cmp_count);
    end
    clear_err();
    run_conv(45, -1, "after_abort");
    d0 = decision;
    strobe(1, d, c, dn, er, dn2);
    checks++;
    if (er !== 1'b1 || d !== d0 || c !== 3'(N)) begin
      errors++;
      $display("FAIL extra_rise: got err=%b dec=%b cnt=%0d expected 1 %b %0d",
               er, d, c, d0, N);
    end
    clear_err();
  endtask

  task automatic test_high_sw();
    logic d, dn, er, dn2;
    logic [2:0] c;
    sample(45);
    strobe(8 | 16, d, c, dn, er, dn2);
    checks++;
    if (er !== 1'b1 || d !== ref_dec(45, 8) || c !== 3'd1) begin
      errors++;
      $display("FAIL high_sw: got err=%b dec=%b cnt=%0d expected 1 %b 1",
               er, d, c, ref_dec(45, 8));
    end
    S = '0;
    S2b = 1'b1;
    step();
    clear_err();
  endtask

  task automatic test_async_reset();
    logic d, dn, er, dn2;
    logic [2:0] c;
    sample(45);
    strobe(8, d, c, dn, er, dn2);
    strobe(12, d, c, dn, er, dn2);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({decision, held_code, cmp_count, conv_done, protocol_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0",
               {decision, held_code, cmp_count, conv_done, protocol_err});
    end
    #1 reset = 1'b1;
    run_conv(45, -1, "post_reset");
  endtask

  task automatic test_random();
    int v;
    for (int k = 0; k < 24; k++) begin
      v = int'($urandom_range(0, (1 << W) - 1));
      run_conv(v, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_conv_45();
    test_extremes();
    test_hold_change();
    test_err_sample();
    test_abort();
    test_high_sw();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
